// File: rtl/ahb_lite_master.sv
// AHB-Lite initiator: turns a valid/ready command stream into pipelined SINGLE transfers.
// Optional error-response handling is compiled in with `define MASTER_HRESP_EN.
module ahb_lite_master #(
  parameter logic [3:0] HPROT_VALUE = 4'b0011
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [2:0]  cmd_size,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [2:0]  HBURST,
  output logic [3:0]  HPROT,
  output logic        HMASTLOCK,
  output logic [31:0] HWDATA,
`ifdef MASTER_HRESP_EN
  input  logic        HRESP,
  output logic        rsp_error,
`endif
  input  logic        HREADY,
  input  logic [31:0] HRDATA
);

  localparam logic [1:0] TRANS_IDLE   = 2'b00;
  localparam logic [1:0] TRANS_NONSEQ = 2'b10;
  localparam logic [2:0] SIZE_WORD    = 3'b010;

  // Address-phase slot: HADDR/HWRITE/HSIZE are the slot's own registers.
  logic        a_valid;
  logic [31:0] a_wdata;
  // Data-phase slot.
  logic        d_valid;
  logic        d_write;

  logic        accept;
  logic        complete;
  logic        err_first;
  logic        err_busy;
  logic        in_err_resp;
  logic        in_err_cancel;

`ifdef MASTER_HRESP_EN
  typedef enum logic [1:0] {
    ST_OK,
    ST_ERR_RESP,
    ST_ERR_CANCEL
  } err_state_t;

  err_state_t err_state;
  err_state_t err_next;
  logic       pend_err;

  // First error cycle: slave signals ERROR while still stalling the data phase.
  assign err_first     = (err_state == ST_OK) && d_valid && HRESP && !HREADY;
  assign err_busy      = (err_state != ST_OK) || (d_valid && HRESP);
  assign in_err_resp   = (err_state == ST_ERR_RESP);
  assign in_err_cancel = (err_state == ST_ERR_CANCEL);

  // NOTE: every variable written here gets a default first, so no path can infer a latch.
  always_comb begin
    err_next = err_state;
    unique case (err_state)
      ST_OK:         if (err_first) err_next = ST_ERR_RESP;
      ST_ERR_RESP:   if (HREADY) err_next = pend_err ? ST_ERR_CANCEL : ST_OK;
      ST_ERR_CANCEL: err_next = ST_OK;
      default:       err_next = ST_OK;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      err_state <= ST_OK;
      pend_err  <= 1'b0;
    end else begin
      err_state <= err_next;
      if (err_first) begin
        pend_err <= a_valid;
      end else if (in_err_cancel) begin
        pend_err <= 1'b0;
      end
    end
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      rsp_error <= 1'b0;
    end else begin
      rsp_error <= (complete && in_err_resp) || in_err_cancel;
    end
  end
`else
  assign err_first     = 1'b0;
  assign err_busy      = 1'b0;
  assign in_err_resp   = 1'b0;
  assign in_err_cancel = 1'b0;
`endif

  // A new command may enter only when slot A is free or is leaving this edge.
  assign cmd_ready = (!a_valid || HREADY) && !err_busy;
  assign accept    = cmd_valid && cmd_ready;
  assign complete  = d_valid && HREADY;

  assign HTRANS    = a_valid ? TRANS_NONSEQ : TRANS_IDLE;
  assign HBURST    = 3'b000;
  assign HPROT     = HPROT_VALUE;
  assign HMASTLOCK = 1'b0;

  // NOTE: state registers use non-blocking assignments so every slot samples pre-edge values.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      a_valid <= 1'b0;
      HADDR   <= 32'd0;
      HWRITE  <= 1'b0;
      HSIZE   <= SIZE_WORD;
      a_wdata <= 32'd0;
      d_valid <= 1'b0;
      d_write <= 1'b0;
      HWDATA  <= 32'd0;
    end else if (err_first) begin
      // Cancel the queued address phase; the data phase keeps waiting for the second error cycle.
      a_valid <= 1'b0;
    end else begin
      if (HREADY) begin
        d_valid <= a_valid;
        d_write <= HWRITE;
        HWDATA  <= a_wdata;
      end
      if (accept) begin
        a_valid <= 1'b1;
        HADDR   <= cmd_addr;
        HWRITE  <= cmd_write;
        HSIZE   <= cmd_size;
        a_wdata <= cmd_wdata;
      end else if (HREADY) begin
        a_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'd0;
    end else begin
      rsp_valid <= complete || in_err_cancel;
      if (complete && !d_write && !in_err_resp) begin
        rsp_rdata <= HRDATA;
      end
    end
  end

endmodule

// File: tb/tb_ahb_lite_master.sv
// Self-checking bench for ahb_lite_master: directed table, hand sequences, and random
// traffic against a transaction-queue reference model.
module tb_ahb_lite_master;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [2:0]  cmd_size;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [3:0]  HPROT;
  logic        HMASTLOCK;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic [31:0] HRDATA;
`ifdef MASTER_HRESP_EN
  logic        HRESP;
  logic        rsp_error;
`endif

  always #5 HCLK = ~HCLK;

  ahb_lite_master #(.HPROT_VALUE(4'b0011)) dut (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_size  (cmd_size),
    .cmd_wdata (cmd_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .HADDR     (HADDR),
    .HTRANS    (HTRANS),
    .HWRITE    (HWRITE),
    .HSIZE     (HSIZE),
    .HBURST    (HBURST),
    .HPROT     (HPROT),
    .HMASTLOCK (HMASTLOCK),
    .HWDATA    (HWDATA),
`ifdef MASTER_HRESP_EN
    .HRESP     (HRESP),
    .rsp_error (rsp_error),
`endif
    .HREADY    (HREADY),
    .HRDATA    (HRDATA)
  );

  int total = 0;
  int bad   = 0;
  logic last_ready;

  // Reference model: commands waiting for / in their address phase, and in their data phase.
  typedef struct packed {
    logic        w;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] wdata;
  } cmd_t;

  cmd_t        addr_q[$];
  cmd_t        data_q[$];
  logic        m_rsp = 1'b0;
  logic [31:0] m_rdata = 32'd0;
  logic        m_after_rst = 1'b0;

  typedef struct packed {
    logic        rst;
    logic        v;
    logic        w;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rd;
    logic [1:0]  e_trans;
    logic        chk_addr;
    logic [31:0] e_addr;
    logic        chk_wd;
    logic [31:0] e_wd;
    logic        e_rsp;
    logic [31:0] e_rdata;
  } vec_t;

  vec_t vecs [12];

  function automatic vec_t mkv(input logic rst, input logic v, input logic w,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [31:0] rd, input logic [1:0] e_trans,
                               input logic chk_addr, input logic [31:0] e_addr,
                               input logic chk_wd, input logic [31:0] e_wd,
                               input logic e_rsp, input logic [31:0] e_rdata);
    vec_t r;
    r.rst = rst;  r.v = v;  r.w = w;  r.addr = addr;  r.wdata = wdata;  r.rd = rd;
    r.e_trans = e_trans;  r.chk_addr = chk_addr;  r.e_addr = e_addr;
    r.chk_wd = chk_wd;  r.e_wd = e_wd;  r.e_rsp = e_rsp;  r.e_rdata = e_rdata;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_outputs();
    check("htrans", 32'(HTRANS), (addr_q.size() != 0) ? 32'd2 : 32'd0);
    if (addr_q.size() != 0) begin
      check("haddr", HADDR, addr_q[0].addr);
      check("hwrite", 32'(HWRITE), 32'(addr_q[0].w));
      check("hsize", 32'(HSIZE), 32'(addr_q[0].size));
    end
    if (data_q.size() != 0 && data_q[0].w) check("hwdata", HWDATA, data_q[0].wdata);
    if (m_after_rst) begin
      check("rst haddr", HADDR, 32'd0);
      check("rst hwrite", 32'(HWRITE), 32'd0);
      check("rst hsize", 32'(HSIZE), 32'd2);
      check("rst hwdata", HWDATA, 32'd0);
    end
    check("rsp_valid", 32'(rsp_valid), 32'(m_rsp));
    check("rsp_rdata", rsp_rdata, m_rdata);
    check("hburst", 32'(HBURST), 32'd0);
    check("hprot", 32'(HPROT), 32'h3);
    check("hmastlock", 32'(HMASTLOCK), 32'd0);
`ifdef MASTER_HRESP_EN
    check("rsp_error", 32'(rsp_error), 32'd0);
`endif
  endtask

  // One clock cycle: drive, check cmd_ready, advance the model, check post-edge outputs.
  task automatic cycle(input logic rst, input logic v, input logic w, input logic [31:0] a,
                       input logic [2:0] s, input logic [31:0] wd, input logic rdy,
                       input logic [31:0] rd);
    logic exp_ready;
    cmd_t c;
    HRESETn = rst;  cmd_valid = v;  cmd_write = w;  cmd_addr = a;  cmd_size = s;
    cmd_wdata = wd;  HREADY = rdy;  HRDATA = rd;
`ifdef MASTER_HRESP_EN
    HRESP = 1'b0;
`endif
    #2;
    last_ready = cmd_ready;
    exp_ready = (addr_q.size() == 0) || rdy;
    check("cmd_ready", 32'(cmd_ready), 32'(exp_ready));
    if (!rst) begin
      addr_q.delete();
      data_q.delete();
      m_rsp = 1'b0;
      m_rdata = 32'd0;
      m_after_rst = 1'b1;
    end else begin
      m_rsp = 1'b0;
      m_after_rst = 1'b0;
      if (rdy) begin
        if (data_q.size() != 0) begin
          c = data_q.pop_front();
          m_rsp = 1'b1;
          if (!c.w) m_rdata = rd;
        end
        if (addr_q.size() != 0) data_q.push_back(addr_q.pop_front());
      end
      if (v && exp_ready) begin
        c.w = w;  c.addr = a;  c.size = s;  c.wdata = wd;
        addr_q.push_back(c);
      end
    end
    @(posedge HCLK);
    #1;
    check_outputs();
  endtask

  task automatic idle(input logic rdy, input logic [31:0] rd);
    cycle(1'b1, 1'b0, 1'b0, 32'd0, 3'd2, 32'd0, rdy, rd);
  endtask

  // Requester-side legality: size at most word, address aligned to size.
  always @(posedge HCLK)
    if (HRESETn === 1'b1 && cmd_valid && cmd_ready)
      assert (cmd_size <= 3'd2 && (cmd_addr & ((32'd1 << cmd_size) - 32'd1)) == 32'd0)
        else $error("requester error: size %0d addr %h", cmd_size, cmd_addr);

`ifdef MASTER_HRESP_EN
  logic resp_wait_q = 1'b0;
  always @(posedge HCLK) begin
    if (HRESETn === 1'b1 && HRESP && HREADY)
      assert (resp_wait_q) else $error("HRESP ERROR completed without a wait cycle");
    resp_wait_q <= HRESP && !HREADY;
  end

  task automatic raw(input logic v, input logic [31:0] a, input logic rdy, input logic resp,
                     input logic [31:0] rd);
    HRESETn = 1'b1;  cmd_valid = v;  cmd_write = 1'b0;  cmd_addr = a;  cmd_size = 3'd2;
    cmd_wdata = 32'd0;  HREADY = rdy;  HRESP = resp;  HRDATA = rd;
    #2;
    last_ready = cmd_ready;
    @(posedge HCLK);
    #1;
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic        rv, rw, rr, ry;
    logic [2:0]  rs;
    logic [31:0] ra;

    HRESETn = 1'b0;  cmd_valid = 1'b0;  cmd_write = 1'b0;  cmd_addr = 32'd0;
    cmd_size = 3'd2;  cmd_wdata = 32'd0;  HREADY = 1'b1;  HRDATA = 32'd0;
`ifdef MASTER_HRESP_EN
    HRESP = 1'b0;
`endif
    repeat (2) @(posedge HCLK);
    #1;

    // Directed table: reset, single read, four back-to-back writes, drain.
    vecs[0]  = mkv(0, 0, 0, 32'h0,         0, 32'hCAFEF00D, 2'd0, 1, 32'h0,         1, 0, 0, 32'h0);
    vecs[1]  = mkv(1, 1, 0, 32'h20000010,  0, 32'hCAFEF00D, 2'd2, 1, 32'h20000010,  0, 0, 0, 32'h0);
    vecs[2]  = mkv(1, 0, 0, 32'h0,         0, 32'hCAFEF00D, 2'd0, 0, 32'h0,         0, 0, 0, 32'h0);
    vecs[3]  = mkv(1, 0, 0, 32'h0,         0, 32'hCAFEF00D, 2'd0, 0, 32'h0,         0, 0, 1, 32'hCAFEF00D);
    vecs[4]  = mkv(1, 0, 0, 32'h0,         0, 32'hCAFEF00D, 2'd0, 0, 32'h0,         0, 0, 0, 32'hCAFEF00D);
    vecs[5]  = mkv(1, 1, 1, 32'h0,         1, 32'hDEAD0000, 2'd2, 1, 32'h0,         0, 0, 0, 32'hCAFEF00D);
    vecs[6]  = mkv(1, 1, 1, 32'h4,         2, 32'hDEAD0000, 2'd2, 1, 32'h4,         1, 1, 0, 32'hCAFEF00D);
    vecs[7]  = mkv(1, 1, 1, 32'h8,         3, 32'hDEAD0000, 2'd2, 1, 32'h8,         1, 2, 1, 32'hCAFEF00D);
    vecs[8]  = mkv(1, 1, 1, 32'hC,         4, 32'hDEAD0000, 2'd2, 1, 32'hC,         1, 3, 1, 32'hCAFEF00D);
    vecs[9]  = mkv(1, 0, 0, 32'h0,         0, 32'hDEAD0000, 2'd0, 0, 32'h0,         1, 4, 1, 32'hCAFEF00D);
    vecs[10] = mkv(1, 0, 0, 32'h0,         0, 32'hDEAD0000, 2'd0, 0, 32'h0,         0, 0, 1, 32'hCAFEF00D);
    vecs[11] = mkv(1, 0, 0, 32'h0,         0, 32'hDEAD0000, 2'd0, 0, 32'h0,         0, 0, 0, 32'hCAFEF00D);

    for (int i = 0; i < 12; i++) begin
      cycle(vecs[i].rst, vecs[i].v, vecs[i].w, vecs[i].addr, 3'd2, vecs[i].wdata, 1'b1, vecs[i].rd);
      check($sformatf("vec%0d htrans", i), 32'(HTRANS), 32'(vecs[i].e_trans));
      if (vecs[i].chk_addr) check($sformatf("vec%0d haddr", i), HADDR, vecs[i].e_addr);
      if (vecs[i].chk_wd) check($sformatf("vec%0d hwdata", i), HWDATA, vecs[i].e_wd);
      check($sformatf("vec%0d rsp_valid", i), 32'(rsp_valid), 32'(vecs[i].e_rsp));
      check($sformatf("vec%0d rsp_rdata", i), rsp_rdata, vecs[i].e_rdata);
    end

    // Idle bus: constant sideband outputs, no transfers, no responses.
    for (int i = 0; i < 5; i++) begin
      idle(1'b1, 32'h0);
      check("idle htrans", 32'(HTRANS), 32'd0);
      check("idle rsp_valid", 32'(rsp_valid), 32'd0);
      check("idle hburst", 32'(HBURST), 32'd0);
      check("idle hprot", 32'(HPROT), 32'h3);
      check("idle hmastlock", 32'(HMASTLOCK), 32'd0);
    end

    // Read then write; slave stalls the read data phase for three cycles.
    cycle(1, 1, 0, 32'h40000000, 3'd2, 32'h0, 1, 32'h0);
    cycle(1, 1, 1, 32'h50000000, 3'd2, 32'h55, 1, 32'h0);
    check("ws haddr", HADDR, 32'h50000000);
    for (int i = 0; i < 3; i++) begin
      cycle(1, 1, 1, 32'h60000000, 3'd2, 32'h66, 0, 32'hFFFFFFFF);
      check("ws cmd_ready", 32'(last_ready), 32'd0);
      check("ws haddr hold", HADDR, 32'h50000000);
      check("ws htrans hold", 32'(HTRANS), 32'd2);
      check("ws rsp_valid", 32'(rsp_valid), 32'd0);
    end
    cycle(1, 0, 0, 32'h0, 3'd2, 32'h0, 1, 32'h12345678);
    check("ws read rsp", 32'(rsp_valid), 32'd1);
    check("ws read data", rsp_rdata, 32'h12345678);
    check("ws hwdata", HWDATA, 32'h55);
    idle(1'b1, 32'hFFFFFFFF);
    check("ws write rsp", 32'(rsp_valid), 32'd1);
    check("ws rdata kept", rsp_rdata, 32'h12345678);
    idle(1'b1, 32'h0);

    // Reset while a read waits in its data phase: dropped with no response.
    cycle(1, 1, 0, 32'h70000000, 3'd2, 32'h0, 1, 32'h0);
    idle(1'b1, 32'h0);
    cycle(0, 0, 0, 32'h0, 3'd2, 32'h0, 0, 32'h0);
    check("mid rst htrans", 32'(HTRANS), 32'd0);
    check("mid rst rsp_valid", 32'(rsp_valid), 32'd0);
    check("mid rst haddr", HADDR, 32'd0);
    check("mid rst rdata", rsp_rdata, 32'd0);
    idle(1'b1, 32'hABCD0000);
    check("post rst rsp_valid", 32'(rsp_valid), 32'd0);

    // Random traffic with wait states and occasional resets.
    for (int i = 0; i < 500; i++) begin
      rv = ($urandom_range(0, 9) < 6);
      rw = $urandom_range(0, 1) == 1;
      rs = 3'($urandom_range(0, 2));
      ra = $urandom & ~((32'd1 << rs) - 32'd1);
      ry = ($urandom_range(0, 3) != 0);
      rr = ($urandom_range(0, 149) != 0);
      cycle(rr, rv, rw, ra, rs, $urandom, ry, $urandom);
    end

`ifdef MASTER_HRESP_EN
    // Error on read A while read B sits in its address phase.
    cycle(0, 0, 0, 32'h0, 3'd2, 32'h0, 1, 32'h0);
    raw(1, 32'h100, 1, 0, 32'h0);
    check("err A htrans", 32'(HTRANS), 32'd2);
    raw(1, 32'h104, 1, 0, 32'h0);
    check("err B haddr", HADDR, 32'h104);
    raw(1, 32'h108, 0, 1, 32'h0);
    check("err1 cmd_ready", 32'(last_ready), 32'd0);
    check("err1 htrans", 32'(HTRANS), 32'd0);
    check("err1 rsp_valid", 32'(rsp_valid), 32'd0);
    raw(1, 32'h108, 1, 1, 32'h0);
    check("err2 cmd_ready", 32'(last_ready), 32'd0);
    check("err2 htrans", 32'(HTRANS), 32'd0);
    check("err A rsp_valid", 32'(rsp_valid), 32'd1);
    check("err A rsp_error", 32'(rsp_error), 32'd1);
    raw(1, 32'h108, 1, 0, 32'h0);
    check("err3 cmd_ready", 32'(last_ready), 32'd0);
    check("err B rsp_valid", 32'(rsp_valid), 32'd1);
    check("err B rsp_error", 32'(rsp_error), 32'd1);
    raw(1, 32'h108, 1, 0, 32'h0);
    check("err done cmd_ready", 32'(last_ready), 32'd1);
    check("err done rsp_valid", 32'(rsp_valid), 32'd0);
    check("err C haddr", HADDR, 32'h108);
    raw(0, 32'h0, 1, 0, 32'h77);
    raw(0, 32'h0, 1, 0, 32'h88);
    check("err C rsp_valid", 32'(rsp_valid), 32'd1);
    check("err C rsp_error", 32'(rsp_error), 32'd0);
    check("err C rdata", rsp_rdata, 32'h88);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ahb_lite_master.md
Name: ahb_lite_master

Overview:
- AHB-Lite initiator that turns a simple valid/ready command stream into pipelined single AHB transfers.
- Drives the bus-side inputs (HADDR etc.) of the AHB interconnect and consumes its muxed HREADY/HRDATA.
- Returns one response per accepted command.
- Supports full address/data-phase overlap: one transfer per cycle at zero wait states.

Parameters:
- HPROT_VALUE, 4'b0011, constant driven on HPROT (non-cacheable, non-bufferable, privileged data).

Ports:
- HCLK  input  1  system clock
- HRESETn  input  1  synchronous active-low reset, sampled on rising HCLK
- cmd_valid  input  1  requester has a command
- cmd_ready  output  1  command accepted at edge when cmd_valid && cmd_ready
- cmd_write  input  1  1 = write, 0 = read
- cmd_addr  input  32  byte address, passed unmodified to HADDR
- cmd_size  input  3  HSIZE value; only 0, 1, 2 legal
- cmd_wdata  input  32  write data, lane-placed by requester
- rsp_valid  output  1  one-cycle pulse per completed command; no backpressure
- rsp_rdata  output  32  read data; holds last value otherwise
- HADDR  output  32  AHB address
- HTRANS  output  2  IDLE (00) or NONSEQ (10) only
- HWRITE  output  1  AHB direction
- HSIZE  output  3  AHB size
- HBURST  output  3  tied 3'b000 (SINGLE)
- HPROT  output  4  tied HPROT_VALUE
- HMASTLOCK  output  1  tied 0
- HWDATA  output  32  write data for the current data phase
- HREADY  input  1  from interconnect
- HRDATA  input  32  from interconnect

Behaviour:
- Reset values (synchronous, HRESETn=0 at edge):
  - HTRANS=IDLE, HADDR=0, HWRITE=0, HSIZE=3'b010, HWDATA=0.
  - rsp_valid=0, rsp_rdata=0.
  - Address-phase and data-phase slots cleared.
- Two slots:
  - A (address phase): a_valid, addr, write, size, wdata.
  - D (data phase): d_valid, write, wdata.
- HTRANS=NONSEQ when a_valid, else IDLE. HADDR/HWRITE/HSIZE come from slot A. All bus outputs are registered.
- cmd_ready = !a_valid || HREADY (combinational from HREADY). Forced 0 during the error sequence when MASTER_HRESP_EN is defined.
- At each edge with HREADY=1:
  - A moves to D (d_valid <= a_valid); HWDATA <= A.wdata.
  - If a command is accepted, it loads into A; otherwise a_valid <= 0.
- At each edge with HREADY=0:
  - A and D hold and all bus outputs hold stable (AHB rule).
  - No command is accepted unless a_valid=0. An accepted command loads A and HTRANS becomes NONSEQ while D is still waiting, which is legal.
- Completion: edge with d_valid && HREADY=1.
  - Next cycle rsp_valid=1.
  - rsp_rdata <= HRDATA for reads; unchanged for writes.
- Latency, acceptance at edge E0 with zero wait states: address phase in cycle after E0, data phase after E1, rsp_valid after E2. Each wait state adds one cycle.
- Throughput: back-to-back commands give continuous NONSEQ and one rsp_valid per cycle.
- Responses are in command order. Idle with no command gives HTRANS=IDLE; the IDLE data phase produces no response.
- Misaligned address or cmd_size>2 is a requester error. There is no correction; the bench flags it with an assertion.
- Reset mid-transfer: all slots dropped, no response for in-flight commands, HTRANS=IDLE the next cycle.

Optional Feature:
- Macro MASTER_HRESP_EN.
- Defined:
  - Adds input HRESP (1 bit) and output rsp_error (1 bit, reset 0, valid with rsp_valid).
  - First error cycle (d_valid, HRESP=1, HREADY=0) triggers a cancel:
    - A is cancelled at that edge and HTRANS=IDLE next cycle.
    - The cancelled command is marked pending-error.
    - cmd_ready=0 until both responses are issued.
  - Second cycle (HRESP=1, HREADY=1) gives rsp_valid with rsp_error=1 for D.
  - The cancelled command (if any) gets rsp_valid with rsp_error=1 on the following cycle, so command/response stay 1:1.
  - HRESP=1 with HREADY=1 on the first cycle is a protocol violation (assertion).
- Undefined: no HRESP/rsp_error ports; HRESP treated as OKAY.

Test Plan:
- Single read 0x2000_0010, HREADY=1, HRDATA=0xCAFE_F00D -> HTRANS=10 one cycle, rsp_valid 2 cycles after acceptance, rsp_rdata=0xCAFE_F00D.
- Four back-to-back writes 0x0,0x4,0x8,0xC, data 1..4, zero wait -> HTRANS=10 for 4 consecutive cycles, HWDATA 1..4 each one cycle after its HADDR, 4 consecutive rsp_valid.
- Read 0x4000_0000 then write 0x5000_0000, slave holds HREADY=0 for 3 cycles in read data phase -> HADDR=0x5000_0000 held stable, cmd_ready=0, read response after 3 extra cycles.
- Reset asserted during data phase of a pending read -> next cycle HTRANS=00, no rsp_valid, outputs at reset values.
- Idle (no cmd_valid) 5 cycles -> HTRANS=00, rsp_valid=0, HBURST=000, HPROT=0011, HMASTLOCK=0.
- MASTER_HRESP_EN: read A errors (HRESP=1,HREADY=0 then HRESP=1,HREADY=1) with read B in address phase -> HTRANS=00 during second error cycle, two rsp_valid pulses both rsp_error=1, cmd_ready low until done.
